rtc_bus_reader: RTL and testbench

Read sequencer for the RTC's multiplexed 8-bit address/data bus. It is the receive-side counterpart of the bus-drive path.
- On a start request it drives the register address with an address strobe.
- It then releases the bus for turnaround, pulses RD_n and captures the byte the RTC returns.
- It sits between the controller FSM and the top-level tri-state AD pad. The pad is driven only while ad_oe=1; ad_in is the pad's input buffer.

---
 rtl/rtc_bus_reader_if.sv | 26 ++
 rtl/rtc_bus_reader.sv | 137 +++++++++++++
 tb/tb_rtc_bus_reader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_reader_if.sv
// Bus bundle between the controller side and the RTC read sequencer.
// The sequencer is the slave; whoever issues reads and owns the pad is the master.
interface rtc_bus_reader_if;
    logic       start;
    logic [7:0] addr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a_d;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    modport master (
        output start, addr, ad_in,
        input  ad_out, ad_oe, cs_n, wr_n, rd_n, a_d, busy, done, data_out
    );

    modport slave (
        input  start, addr, ad_in,
        output ad_out, ad_oe, cs_n, wr_n, rd_n, a_d, busy, done, data_out
    );
endinterface

// File: rtl/rtc_bus_reader.sv
// Read sequencer for the RTC multiplexed AD bus: address phase with WR_n strobe,
// bus turnaround, then an RD_n pulse whose last cycle captures the returned byte.
module rtc_bus_reader #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_TURN  = 2,
    parameter int unsigned CNT_W   = 4
) (
    input logic             clk,
    input logic             reset_n,
    rtc_bus_reader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StAsetup, StAwr, StAhold, StTurn, StDrd, StFinish
    } state_e;

    localparam logic [CNT_W-1:0] SetupLast = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] TurnLast  = CNT_W'(T_TURN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       ad_out_q;
    logic [7:0]       data_q;
    logic             ad_oe_q;
    logic             cs_n_q;
    logic             wr_n_q;
    logic             rd_n_q;
    logic             a_d_q;
    logic             busy_q;
    logic             done_q;

    // Outputs are set on the edge that enters a state, so they are valid for its whole span.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ad_out_q <= 8'h00;
            data_q   <= 8'h00;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q  <= StAsetup;
                        cnt_q    <= '0;
                        ad_out_q <= bus.addr;
                        ad_oe_q  <= 1'b1;
                        cs_n_q   <= 1'b0;
                        a_d_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StAsetup: begin
                    if (cnt_q == SetupLast) begin
                        state_q <= StAwr;
                        cnt_q   <= '0;
                        wr_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAwr: begin
                    if (cnt_q == PulseLast) begin
                        state_q <= StAhold;
                        cnt_q   <= '0;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAhold: begin
                    if (cnt_q == HoldLast) begin
                        state_q <= StTurn;
                        cnt_q   <= '0;
                        ad_oe_q <= 1'b0;
                        a_d_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StTurn: begin
                    if (cnt_q == TurnLast) begin
                        state_q <= StDrd;
                        cnt_q   <= '0;
                        rd_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrd: begin
                    // Only the value present at the edge ending the strobe is trusted.
                    if (cnt_q == PulseLast) begin
                        state_q <= StFinish;
                        cnt_q   <= '0;
                        rd_n_q  <= 1'b1;
                        cs_n_q  <= 1'b1;
                        data_q  <= bus.ad_in;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ad_out   = ad_out_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.a_d      = a_d_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Bench for rtc_bus_reader: a default-timing and an all-ones-timing instance share inputs and
// are checked every cycle against a timeline model plus literal latency/data expectations.
module tb_rtc_bus_reader;

    localparam int TS [2] = '{2, 1};
    localparam int TP [2] = '{4, 1};
    localparam int TH [2] = '{2, 1};
    localparam int TT [2] = '{2, 1};

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] addr    = 8'h00;
    logic [7:0] ad_in   = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt [2];
    int done_q0 [$];
    int last_done1 = -100;

    // Model state: offset of the current cycle from the accepting edge (0 = idle).
    int         m_off  [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_data [2];

    rtc_bus_reader_if bi0 ();
    rtc_bus_reader_if bi1 ();

    assign bi0.start = start;
    assign bi0.addr  = addr;
    assign bi0.ad_in = ad_in;
    assign bi1.start = start;
    assign bi1.addr  = addr;
    assign bi1.ad_in = ad_in;

    rtc_bus_reader u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bi0)
    );

    rtc_bus_reader #(
        .T_SETUP (1),
        .T_PULSE (1),
        .T_HOLD  (1),
        .T_TURN  (1),
        .CNT_W   (4)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bi1)
    );

    // {busy, done, cs_n, wr_n, rd_n, a_d, ad_oe, ad_out, data_out}
    wire [22:0] got0 = {bi0.busy, bi0.done, bi0.cs_n, bi0.wr_n, bi0.rd_n, bi0.a_d, bi0.ad_oe,
                        bi0.ad_out, bi0.data_out};
    wire [22:0] got1 = {bi1.busy, bi1.done, bi1.cs_n, bi1.wr_n, bi1.rd_n, bi1.a_d, bi1.ad_oe,
                        bi1.ad_out, bi1.data_out};

    always #5 clk = ~clk;

    function automatic int total(input int i);
        return TS[i] + 2 * TP[i] + TH[i] + TT[i];
    endfunction

    function automatic logic [22:0] expect_vec(input int i);
        int   o, a1, a2, a3, a4, a5;
        logic busy, done, cs_n, wr_n, rd_n, a_d, ad_oe;
        o  = m_off[i];
        a1 = TS[i];
        a2 = a1 + TP[i];
        a3 = a2 + TH[i];
        a4 = a3 + TT[i];
        a5 = a4 + TP[i];
        busy  = (o != 0);
        done  = (o == a5 + 1);
        cs_n  = !(o >= 1 && o <= a5);
        wr_n  = !(o > a1 && o <= a2);
        ad_oe = (o >= 1 && o <= a3);
        a_d   = !ad_oe;
        rd_n  = !(o > a4 && o <= a5);
        return {busy, done, cs_n, wr_n, rd_n, a_d, ad_oe, m_addr[i], m_data[i]};
    endfunction

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_off[i]  = 0;
            m_addr[i] = 8'h00;
            m_data[i] = 8'h00;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_off[i]  = 0;
                    m_addr[i] = 8'h00;
                    m_data[i] = 8'h00;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_off[i] == 0) begin
                        if (start) begin
                            m_off[i]  = 1;
                            m_addr[i] = addr;
                        end
                    end else if (m_off[i] == total(i) + 1) begin
                        m_off[i] = 0;
                    end else begin
                        if (m_off[i] == total(i)) m_data[i] = ad_in;
                        m_off[i] = m_off[i] + 1;
                    end
                end
            end
        end
    end

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [22:0] g, e;
                g = (i == 0) ? got0 : got1;
                e = expect_vec(i);
                n_vec++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL outputs dut%0d cycle %0d: got %h want %h", i, cyc + 1, g, e);
                end
                n_vec++;
                if (g[16] !== 1'b0 && g[18] !== 1'b1) begin
                    n_err++;
                    $display("FAIL bus_conflict dut%0d cycle %0d: ad_oe=%b rd_n=%b want not (1,0)",
                             i, cyc + 1, g[16], g[18]);
                end
                n_vec++;
                if (g[19] !== 1'b1 && g[18] !== 1'b1) begin
                    n_err++;
                    $display("FAIL strobe_overlap dut%0d cycle %0d: wr_n=%b rd_n=%b want not (0,0)",
                             i, cyc + 1, g[19], g[18]);
                end
                if (g[21] === 1'b1) begin
                    done_cnt[i]++;
                    if (i == 0) done_q0.push_back(cyc + 1);
                    else last_done1 = cyc + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int done_back(input int n);
        if (done_q0.size() > n) return done_q0[done_q0.size() - 1 - n];
        return -1000;
    endfunction

    // Drives one start pulse in cycle k and runs through cycle k+16. ad_in switches to
    // 'late' only for the last DRD cycle of the default-timing instance.
    task automatic do_read(input logic [7:0] a, input logic [7:0] early, input logic [7:0] late,
                           input bit repulse, output int k);
        @(negedge clk);
        #1;
        start = 1'b1;
        addr  = a;
        ad_in = early;
        k     = cyc + 1;
        for (int c = k + 1; c <= k + 16; c++) begin
            @(negedge clk);
            #1;
            start = repulse && (c == k + 5 || c == k + 15);
            if (start) addr = 8'h05;
            if (c == k + 14) ad_in = late;
        end
        start = 1'b0;
    endtask

    initial begin
        int k, n0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_cs_n", int'(bi0.cs_n), 1);
        check("rst_a_d", int'(bi0.a_d), 1);
        check("rst_ad_oe", int'(bi0.ad_oe), 0);
        check("rst_data", int'(bi0.data_out), 0);

        // Basic read, both timings.
        n0 = done_cnt[0];
        do_read(8'h21, 8'h59, 8'h59, 1'b0, k);
        check("t1_done_count", done_cnt[0], n0 + 1);
        check("t1_latency", done_back(0) - k, 15);
        check("t1_data", int'(bi0.data_out), 8'h59);
        check("t6_latency", last_done1 - k, 6);
        check("t6_data", int'(bi1.data_out), 8'h59);

        // Only the last DRD cycle's value is captured.
        repeat (3) @(negedge clk);
        do_read(8'h21, 8'hAA, 8'h3C, 1'b0, k);
        check("t2_late_data", int'(bi0.data_out), 8'h3C);
        check("t6_early_data", int'(bi1.data_out), 8'hAA);
        repeat (4) @(negedge clk);
        do_read(8'h12, 8'hFF, 8'hFF, 1'b0, k);
        check("t2_next_data", int'(bi0.data_out), 8'hFF);

        // Starts while busy are dropped.
        repeat (4) @(negedge clk);
        n0 = done_cnt[0];
        do_read(8'h21, 8'h66, 8'h66, 1'b1, k);
        check("t3_done_count", done_cnt[0], n0 + 1);
        check("t3_ad_out", int'(bi0.ad_out), 8'h21);
        check("t3_data", int'(bi0.data_out), 8'h66);

        // Back-to-back with start held high.
        repeat (10) @(negedge clk);
        n0 = done_cnt[0];
        @(negedge clk);
        #1;
        start = 1'b1;
        addr  = 8'h33;
        ad_in = 8'h4B;
        k     = cyc + 1;
        for (int t = 0; t < 60 && done_cnt[0] < n0 + 2; t++) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        check("t4_done_count", done_cnt[0], n0 + 2);
        check("t4_first_latency", done_back(1) - k, 15);
        check("t4_period", done_back(0) - done_back(1), 16);

        // Reset pulse in the middle of the WR_n strobe.
        repeat (12) @(negedge clk);
        #1;
        start = 1'b1;
        addr  = 8'h44;
        ad_in = 8'h77;
        k     = cyc + 1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t5_in_awr", int'(bi0.wr_n), 0);
        #1;
        reset_n = 1'b0;
        n0 = done_cnt[0];
        #1;
        check("t5_cs_n", int'(bi0.cs_n), 1);
        check("t5_wr_n", int'(bi0.wr_n), 1);
        check("t5_ad_oe", int'(bi0.ad_oe), 0);
        check("t5_busy", int'(bi0.busy), 0);
        check("t5_data_cleared", int'(bi0.data_out), 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t5_no_done", done_cnt[0], n0);
        do_read(8'h21, 8'h5A, 8'h5A, 1'b0, k);
        check("t5_recover_latency", done_back(0) - k, 15);
        check("t5_recover_data", int'(bi0.data_out), 8'h5A);

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 7) == 0);
            addr  = 8'($urandom);
            ad_in = 8'($urandom);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
